// File: rtl/alu_ctrl_seq.sv
// Sequenced ALU control unit: decodes one request per cycle into a registered
// alucontrol code and sequences multi-cycle mult/div with a countdown.
module alu_ctrl_seq #(
  parameter int unsigned OP_W       = 5,
  parameter int unsigned CTRL_W     = 4,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 16,
  parameter int unsigned CNT_W      = $clog2((MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [OP_W-1:0]   op,
  input  logic [1:0]        aluop,
  input  logic              flush,
  output logic              in_ready,
  output logic [CTRL_W-1:0] alucontrol,
  output logic              out_valid,
  output logic              illegal,
  output logic              busy,
  output logic              alu_start
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [CTRL_W-1:0]  alucontrol_n;
  logic               out_valid_n, illegal_n, busy_n, alu_start_n;

  logic               op_hi;
  logic [3:0]         dec_code;
  logic               dec_ill, dec_multi;
  logic [CNT_W-1:0]   dec_load;
  logic               accept;

  // Any set bit above the 5-bit decoded field makes the op undefined.
  assign op_hi = |(op >> 5);

  // Op decode: code, legality, and countdown load for multi-cycle ops.
  always_comb begin
    dec_code  = 4'h0;
    dec_ill   = 1'b0;
    dec_multi = 1'b0;
    dec_load  = '0;
    case (aluop)
      2'b00: dec_code = 4'h0;
      2'b11: dec_code = 4'h1;
      default: begin
        if (op_hi) begin
          dec_ill = 1'b1;
        end else begin
          case (op[4:0])
            5'b00001: dec_code = 4'h0;
            5'b01001: dec_code = 4'h1;
            5'b01010: begin dec_code = 4'h2; dec_multi = 1'b1; dec_load = MUL_LOAD; end
            5'b01011: begin dec_code = 4'h3; dec_multi = 1'b1; dec_load = DIV_LOAD; end
            5'b01100: dec_code = 4'h4;
            5'b01101: dec_code = 4'h5;
            5'b01110: dec_code = 4'h6;
            5'b01111: dec_code = 4'h7;
            5'b10000: dec_code = 4'h8;
            5'b10001: dec_code = 4'h9;
            5'b10010: dec_code = 4'hA;
            5'b10011: dec_code = 4'hB;
            5'b10100: dec_code = 4'hC;
            5'b10101: dec_code = 4'hD;
            5'b10110: dec_code = 4'hE;
            default:  dec_ill  = 1'b1;
          endcase
        end
      end
    endcase
  end

  assign in_ready = (state == IDLE) && !reset;
  assign accept   = in_valid && in_ready && !flush;

  // Next-state and next-output logic.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    alucontrol_n = alucontrol;
    out_valid_n  = 1'b0;
    illegal_n    = 1'b0;
    alu_start_n  = 1'b0;
    busy_n       = busy;
    case (state)
      IDLE: begin
        if (accept) begin
          alucontrol_n = dec_ill ? '0 : CTRL_W'(dec_code);
          if (dec_multi) begin
            state_n     = BUSY;
            cnt_n       = dec_load;
            busy_n      = 1'b1;
            alu_start_n = 1'b1;
          end else begin
            out_valid_n = 1'b1;
            illegal_n   = dec_ill;
          end
        end
      end
      BUSY: begin
        if (flush) begin
          // Abort: drop the op silently, keep the last code on alucontrol.
          state_n = IDLE;
          cnt_n   = '0;
          busy_n  = 1'b0;
        end else if (cnt == CNT_ONE) begin
          state_n     = IDLE;
          cnt_n       = '0;
          busy_n      = 1'b0;
          out_valid_n = 1'b1;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      alucontrol <= '0;
      out_valid  <= 1'b0;
      illegal    <= 1'b0;
      busy       <= 1'b0;
      alu_start  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      alucontrol <= alucontrol_n;
      out_valid  <= out_valid_n;
      illegal    <= illegal_n;
      busy       <= busy_n;
      alu_start  <= alu_start_n;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq (OP_W=6 so the upper-bit illegal path is reachable).
module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [5:0] op;
  logic [1:0] aluop;
  logic       flush;
  logic       in_ready;
  logic [3:0] alucontrol;
  logic       out_valid;
  logic       illegal;
  logic       busy;
  logic       alu_start;

  int n_cmp = 0;
  int n_err = 0;

  alu_ctrl_seq #(
    .OP_W(6), .CTRL_W(4), .MUL_CYCLES(4), .DIV_CYCLES(16)
  ) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .aluop(aluop),
    .flush(flush), .in_ready(in_ready), .alucontrol(alucontrol),
    .out_valid(out_valid), .illegal(illegal), .busy(busy), .alu_start(alu_start)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs in one call: alucontrol, out_valid, illegal, busy, alu_start, in_ready.
  task automatic chk_all(input string tag, input logic [3:0] ac, input logic ov,
                         input logic il, input logic bz, input logic st, input logic rdy);
    chk({tag, ".alucontrol"}, 32'(alucontrol), 32'(ac));
    chk({tag, ".out_valid"},  32'(out_valid),  32'(ov));
    chk({tag, ".illegal"},    32'(illegal),    32'(il));
    chk({tag, ".busy"},       32'(busy),       32'(bz));
    chk({tag, ".alu_start"},  32'(alu_start),  32'(st));
    chk({tag, ".in_ready"},   32'(in_ready),   32'(rdy));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; op = '0; aluop = 2'b00; flush = 1'b0;
    tick(); tick();
    chk_all("reset", 4'h0, 0, 0, 0, 0, 0);
    reset = 1'b0; #1;
    chk("post_reset.in_ready", 32'(in_ready), 32'd1);

    // Single-cycle and op
    in_valid = 1'b1; aluop = 2'b10; op = 6'b001110;
    tick();
    chk_all("and", 4'h6, 1, 0, 0, 0, 1);

    // Back-to-back: add, sub, sgt
    aluop = 2'b00; tick(); chk_all("b2b_add", 4'h0, 1, 0, 0, 0, 1);
    aluop = 2'b11; tick(); chk_all("b2b_sub", 4'h1, 1, 0, 0, 0, 1);
    aluop = 2'b10; op = 6'b010110; tick(); chk_all("b2b_sgt", 4'hE, 1, 0, 0, 0, 1);
    in_valid = 1'b0; tick(); chk_all("hold", 4'hE, 0, 0, 0, 0, 1);

    // Mult, MUL_CYCLES=4, with an add request held during BUSY
    in_valid = 1'b1; aluop = 2'b10; op = 6'b001010;
    tick(); chk_all("mul_t1", 4'h2, 0, 0, 1, 1, 0);
    aluop = 2'b00;
    tick(); chk_all("mul_t2", 4'h2, 0, 0, 1, 0, 0);
    tick(); chk_all("mul_t3", 4'h2, 0, 0, 1, 0, 0);
    tick(); chk_all("mul_t4", 4'h2, 1, 0, 0, 0, 1);
    tick(); chk_all("mul_t5_add", 4'h0, 1, 0, 0, 0, 1);

    // Illegal ops: undefined low field and a set upper bit
    aluop = 2'b10; op = 6'b001111; tick(); chk_all("or", 4'h7, 1, 0, 0, 0, 1);
    op = 6'b011111; tick(); chk_all("ill_low", 4'h0, 1, 1, 0, 0, 1);
    aluop = 2'b10; op = 6'b001110; tick(); chk_all("and2", 4'h6, 1, 0, 0, 0, 1);
    aluop = 2'b01; op = 6'b100001; tick(); chk_all("ill_hi", 4'h0, 1, 1, 0, 0, 1);
    in_valid = 1'b0; tick(); chk_all("ill_idle", 4'h0, 0, 0, 0, 0, 1);

    // Full div, DIV_CYCLES=16
    in_valid = 1'b1; aluop = 2'b10; op = 6'b001011;
    tick(); chk_all("div_t1", 4'h3, 0, 0, 1, 1, 0);
    in_valid = 1'b0;
    for (int k = 2; k <= 15; k++) begin
      tick();
      chk($sformatf("div_t%0d.busy", k), 32'(busy), 32'd1);
      chk($sformatf("div_t%0d.out_valid", k), 32'(out_valid), 32'd0);
    end
    tick(); chk_all("div_t16", 4'h3, 1, 0, 0, 0, 1);

    // Div flushed in cycle T+5
    aluop = 2'b11; in_valid = 1'b1; tick(); chk_all("sub", 4'h1, 1, 0, 0, 0, 1);
    aluop = 2'b10; op = 6'b001011;
    tick(); chk_all("dfl_t1", 4'h3, 0, 0, 1, 1, 0);
    in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    chk_all("dfl_t5", 4'h3, 0, 0, 1, 0, 0);
    flush = 1'b1;
    tick(); chk_all("dfl_t6", 4'h3, 0, 0, 0, 0, 1);
    flush = 1'b0;
    for (int k = 7; k <= 20; k++) begin
      tick();
      chk($sformatf("dfl_t%0d.out_valid", k), 32'(out_valid), 32'd0);
    end

    // Div with reset in cycle T+5
    in_valid = 1'b1; aluop = 2'b10; op = 6'b001011;
    tick(); chk_all("drs_t1", 4'h3, 0, 0, 1, 1, 0);
    in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    reset = 1'b1; flush = 1'b1;
    tick(); chk_all("drs_t6", 4'h0, 0, 0, 0, 0, 0);
    reset = 1'b0; flush = 1'b0; #1;
    chk("drs_rel.in_ready", 32'(in_ready), 32'd1);
    for (int k = 7; k <= 20; k++) begin
      tick();
      chk($sformatf("drs_t%0d.out_valid", k), 32'(out_valid), 32'd0);
    end

    // Flush in IDLE drops the request; the same request without flush is taken
    in_valid = 1'b1; aluop = 2'b10; op = 6'b001101; flush = 1'b1;
    tick(); chk_all("idle_flush", 4'h0, 0, 0, 0, 0, 1);
    flush = 1'b0;
    tick(); chk_all("idle_sr", 4'h5, 1, 0, 0, 0, 1);
    in_valid = 1'b0;
    tick(); chk_all("end_idle", 4'h5, 0, 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Sequenced ALU control unit: parametrised successor of the combinational ALU decoder. It accepts one decode request per cycle through a valid/ready handshake and produces a registered `alucontrol` code. It also sequences the multi-cycle operations (mult, div) that the single-cycle datapath cannot complete: it holds off new requests and reports completion after a configurable latency. It sits between the main decoder and the ALU/multiplier-divider unit and drives the pipeline stall for multi-cycle ops.

## Interface
- `OP_W`, 5: opcode width. Bits [4:0] are decoded. Any nonzero bit above bit 4 makes the op illegal.
- `CTRL_W`, 4: `alucontrol` width. Must be ≥4; upper bits are driven 0.
- `MUL_CYCLES`, 4: total latency of mult, accept edge to `out_valid`. Must be ≥2.
- `DIV_CYCLES`, 16: total latency of div. Must be ≥2.
- `CNT_W`, $clog2(max(MUL_CYCLES,DIV_CYCLES)): countdown width. Derived; do not override.

Ports (clock and reset first):
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: a decode request is present.
- `op` in OP_W: function/opcode field.
- `aluop` in 2: class from the main decoder.
- `flush` in 1: synchronous abort of any in-flight op.
- `in_ready` out 1: request can be accepted (combinational, = state IDLE and not reset).
- `alucontrol` out CTRL_W: registered ALU control code.
- `out_valid` out 1: one-cycle pulse when `alucontrol` for a request is final.
- `illegal` out 1: qualifies `out_valid`; the op is undefined.
- `busy` out 1: multi-cycle op in flight (stall request to the pipeline).
- `alu_start` out 1: one-cycle pulse that launches the mult/div unit.

## Operation
- Accept occurs on a rising edge with `in_valid & in_ready & ~flush`.
- Decode, by `aluop`:
  - 00 → 0000 (add).
  - 11 → 0001 (sub).
  - 01 or 10 → decode `op`: 00001 add 0000; 01001 sub 0001; 01010 mult 0010*; 01011 div 0011*; 01100 sl 0100; 01101 sr 0101; 01110 and 0110; 01111 or 0111; 10000 xor 1000; 10001 nor 1001; 10010 jr 1010; 10011 nand 1011; 10100 not 1100; 10101 slt 1101; 10110 sgt 1110.
  - Any other `op` is illegal. \* marks a multi-cycle op.
- Illegal op: `alucontrol` = 0 (never X), `illegal` = 1 with `out_valid`. No stall.
- FSM states: IDLE and BUSY.
  - IDLE, accept single-cycle or illegal op: stay IDLE.
  - IDLE, accept mult/div: go to BUSY. Load count = N−1, where N = MUL_CYCLES or DIV_CYCLES.
  - BUSY: count decrements each cycle. On the edge where count = 1, go to IDLE and register `out_valid` = 1.
  - BUSY, `flush`: go to IDLE on the next edge. No `out_valid`; `busy` and `alu_start` clear; `alucontrol` holds its value.
  - IDLE, `flush`: the request is dropped (not accepted).
- `alucontrol` holds its last value between requests. `illegal` is 0 whenever `out_valid` is 0.
- `reset` overrides everything, including `flush` and any op in flight. Mid-BUSY reset returns to IDLE with no completion pulse.

## Timing
- Reset values: `alucontrol` = 0, `out_valid` = 0, `illegal` = 0, `busy` = 0, `alu_start` = 0, state IDLE, count 0. `in_ready` = 0 while `reset` is high and 1 on the first cycle after.
- Single-cycle op accepted at edge T: `alucontrol` and `out_valid` = 1 during cycle T+1 (latency 1). `in_ready` stays high, so throughput is 1 op/cycle and back-to-back requests give consecutive pulses.
- Mult/div accepted at edge T:
  - cycle T+1: `alucontrol` = code, `alu_start` = 1 (one cycle only), `busy` = 1, `in_ready` = 0.
  - cycle T+N: `out_valid` = 1, `busy` = 0, `in_ready` = 1. A new request is accepted at the end of that same cycle (zero bubble).
- `busy` is high for exactly N−1 cycles: T+1 … T+N−1.
- `in_valid` while `in_ready` = 0 is ignored. The requester must hold it.

## Test plan
- Reset, then aluop=10, op=01110 at edge 1 → cycle 2: alucontrol=0110, out_valid=1, illegal=0, busy=0.
- Back-to-back aluop=00, then aluop=11, then aluop=10/op=10110 → three consecutive out_valid pulses with 0000, 0001, 1110.
- aluop=10, op=01010 (mult), MUL_CYCLES=4 → alu_start high only at T+1; busy high T+1..T+3; out_valid and alucontrol=0010 at T+4; a held add request is accepted at T+4 and completes at T+5.
- aluop=10, op=11111, and OP_W=6 with op=100001 → out_valid=1, illegal=1, alucontrol=0000, no stall.
- div (DIV_CYCLES=16), flush at T+5 → busy=0 and in_ready=1 at T+6; no out_valid through T+20. Repeat with reset at T+5 → all outputs at reset values at T+6.
- Flush asserted with in_valid in IDLE → no out_valid next cycle; the same request without flush is accepted normally.
